// File: rtl/simon_pkg.sv
// Shared constants and types for the two-share SIMON-128/128 key schedule.
package simon_pkg;

    localparam int KW      = 64;
    localparam int NROUNDS = 68;
    localparam int ZLEN    = 62;
    localparam int RND_W   = 7;

    localparam logic [KW-1:0]    SIMON_C  = 64'hFFFF_FFFF_FFFF_FFFC;
    // Bit j holds the j-th character of the z2 string, so z_sr[0] is the first z bit used.
    localparam logic [ZLEN-1:0]  SIMON_Z2 =
        62'b110011011010_0111111000_1000010100_0110010010_1100000011_1011110101;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NROUNDS - 1);

    localparam logic [1:0] RDY_LOAD = 2'd1;
    localparam logic [1:0] RDY_RUN  = 2'd3;

    typedef struct packed {
        logic [KW-1:0] k1;
        logic [KW-1:0] k0;
    } share_t;

endpackage

// File: rtl/simon_key_share_step.sv
// One key-expansion step for a single share; the round constant is added only when add_const is set.
// Latency: combinational.
// Backpressure: none.
module simon_key_share_step
    import simon_pkg::*;
(
    input  logic [KW-1:0] k0,
    input  logic [KW-1:0] k1,
    input  logic          zbit,
    input  logic          add_const,
    output logic [KW-1:0] k_next
);

    logic [KW-1:0] rc;
    logic [KW-1:0] k1_ror3;
    logic [KW-1:0] k1_ror4;

    assign k1_ror3 = {k1[2:0], k1[KW-1:3]};
    assign k1_ror4 = {k1[3:0], k1[KW-1:4]};

    always_comb begin
        rc = '0;
        if (add_const) begin
            rc = SIMON_C ^ {{(KW-1){1'b0}}, zbit};
        end
        k_next = k0 ^ k1_ror3 ^ k1_ror4 ^ rc;
    end

endmodule

// File: rtl/simon_key_share_sched.sv
// Two-share SIMON-128/128 key schedule; shares expand independently, constant on share A only.
// Latency: round-0 key visible directly after load; one update per odd-counter cycle, saturating at round 67.
// Backpressure: none; data_rdy 0/2 (and even counter) hold all state.
module simon_key_share_sched
    import simon_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    data_rdy,
    input  logic [7:0]    counter,
    input  logic          key_bit_a,
    input  logic          key_bit_b,
    output logic [KW-1:0] key_ina,
    output logic [KW-1:0] key_inb,
    output logic          key_last
);

    share_t           sh_a;
    share_t           sh_b;
    logic [ZLEN-1:0]  z_sr;
    logic [RND_W-1:0] rnd;
    logic [KW-1:0]    next_a;
    logic [KW-1:0]    next_b;
    logic             do_load;
    logic             do_step;
    logic             unused_counter_hi;

    assign unused_counter_hi = ^counter[7:1];

    assign do_load = (data_rdy == RDY_LOAD);
    assign do_step = (data_rdy == RDY_RUN) && counter[0] && (rnd < LAST_RND);

    simon_key_share_step u_step_a (
        .k0        (sh_a.k0),
        .k1        (sh_a.k1),
        .zbit      (z_sr[0]),
        .add_const (1'b1),
        .k_next    (next_a)
    );

    simon_key_share_step u_step_b (
        .k0        (sh_b.k0),
        .k1        (sh_b.k1),
        .zbit      (z_sr[0]),
        .add_const (1'b0),
        .k_next    (next_b)
    );

    // Serial load shifts {K1,K0} right by one with the new bit entering at K1[63].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a <= '0;
            sh_b <= '0;
            z_sr <= SIMON_Z2;
            rnd  <= '0;
        end else if (do_load) begin
            sh_a.k1 <= {key_bit_a, sh_a.k1[KW-1:1]};
            sh_a.k0 <= {sh_a.k1[0], sh_a.k0[KW-1:1]};
            sh_b.k1 <= {key_bit_b, sh_b.k1[KW-1:1]};
            sh_b.k0 <= {sh_b.k1[0], sh_b.k0[KW-1:1]};
            z_sr    <= SIMON_Z2;
            rnd     <= '0;
        end else if (do_step) begin
            sh_a.k0 <= sh_a.k1;
            sh_a.k1 <= next_a;
            sh_b.k0 <= sh_b.k1;
            sh_b.k1 <= next_b;
            z_sr    <= {z_sr[0], z_sr[ZLEN-1:1]};
            rnd     <= rnd + 1'b1;
        end
    end

    assign key_ina  = sh_a.k0;
    assign key_inb  = sh_b.k0;
    assign key_last = (rnd == LAST_RND);

endmodule

// File: tb/tb_simon_key_share_sched.sv
// Bench for the two-share SIMON-128/128 key schedule: scoreboard of expected shares, XOR key and key_last.
module tb_simon_key_share_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  data_rdy;
    logic [7:0]  counter;
    logic        key_bit_a;
    logic        key_bit_b;
    logic [63:0] key_ina;
    logic [63:0] key_inb;
    logic        key_last;

    simon_key_share_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_rdy  (data_rdy),
        .counter   (counter),
        .key_bit_a (key_bit_a),
        .key_bit_b (key_bit_b),
        .key_ina   (key_ina),
        .key_inb   (key_inb),
        .key_last  (key_last)
    );

    always #5 clk = ~clk;

    localparam logic [63:0]  C64  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KEY2 = 128'h1f1e1d1c1b1a1918_1716151413121110;
    localparam logic [127:0] PT1  = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] CT1  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    typedef struct packed {
        logic [7:0]  t;
        logic [7:0]  idx;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] ek;
        logic        el;
        logic        rec;
        logic        fin;
    } item_t;

    item_t       sb[$];
    logic [63:0] ks_a [0:67];
    logic [63:0] ks_b [0:67];
    logic [63:0] ks_k [0:67];
    logic [63:0] obs_k [0:67];
    int          mrnd;
    int          total = 0;
    int          bad = 0;
    logic        obs_vld = 1'b0;
    logic        done_req = 1'b0;
    logic        done_ack = 1'b0;

    function automatic logic zbit(input int j);
        string zs;
        zs = "10101111011100000011010010011000101000010001111110010110110011";
        return zs[j % 62] == 8'h31;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] expand(input logic [63:0] a, input logic [63:0] b,
                                           input int i, input logic addc);
        logic [63:0] r;
        r = a ^ rotr(b, 3) ^ rotr(b, 4);
        if (addc) r = r ^ C64 ^ {63'b0, zbit(i)};
        return r;
    endfunction

    task automatic build(input logic [127:0] a, input logic [127:0] b, input logic [127:0] k);
        ks_a[0] = a[63:0]; ks_a[1] = a[127:64];
        ks_b[0] = b[63:0]; ks_b[1] = b[127:64];
        ks_k[0] = k[63:0]; ks_k[1] = k[127:64];
        for (int i = 0; i < 66; i++) begin
            ks_a[i+2] = expand(ks_a[i], ks_a[i+1], i, 1'b1);
            ks_b[i+2] = expand(ks_b[i], ks_b[i+1], i, 1'b0);
            ks_k[i+2] = expand(ks_k[i], ks_k[i+1], i, 1'b1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_keys(input logic [7:0] t, input logic [7:0] idx, input logic [63:0] ea,
                               input logic [63:0] eb, input logic [63:0] ek, input logic el,
                               input logic rec, input logic fin);
        item_t it;
        it.t = t; it.idx = idx; it.ea = ea; it.eb = eb; it.ek = ek;
        it.el = el; it.rec = rec; it.fin = fin;
        sb.push_back(it);
        obs_vld = 1'b1;
        @(negedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    task automatic expect_model(input logic [7:0] t, input logic rec, input logic fin);
        expect_keys(t, 8'(mrnd), ks_a[mrnd], ks_b[mrnd], ks_k[mrnd], mrnd == 67, rec, fin);
    endtask

    task automatic load_keys(input logic [127:0] a, input logic [127:0] b, input logic [127:0] k);
        data_rdy = 2'd1;
        for (int i = 0; i < 128; i++) begin
            key_bit_a = a[i];
            key_bit_b = b[i];
            tick();
        end
        data_rdy  = 2'd0;
        key_bit_a = 1'b0;
        key_bit_b = 1'b0;
        build(a, b, k);
        mrnd = 0;
    endtask

    task automatic run(input logic [7:0] t, input int c_from, input int c_to, input logic rec);
        for (int c = c_from; c <= c_to; c++) begin
            data_rdy = 2'd3;
            counter  = 8'(c);
            tick();
            if ((c % 2 == 1) && mrnd < 67) mrnd++;
            expect_model(t, rec, rec && (c == c_to));
        end
    endtask

    task automatic hold(input logic [7:0] t, input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            data_rdy = code;
            counter  = 8'd1;
            tick();
            expect_model(t, 1'b0, 1'b0);
        end
    endtask

    // Monitor: pops one expected item whenever the driver presents an observation.
    always @(negedge clk) begin
        item_t       it;
        logic [63:0] x, y, tmp;
        if (obs_vld) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow got_items=0 want_items>0");
            end else begin
                it = sb.pop_front();
                if (key_ina !== it.ea || key_inb !== it.eb) begin
                    bad++;
                    $display("FAIL t%0d.r%0d shares got a=%h b=%h want a=%h b=%h",
                             it.t, it.idx, key_ina, key_inb, it.ea, it.eb);
                end
                total++;
                if ((key_ina ^ key_inb) !== it.ek) begin
                    bad++;
                    $display("FAIL t%0d.r%0d xor_key got=%h want=%h",
                             it.t, it.idx, key_ina ^ key_inb, it.ek);
                end
                total++;
                if (key_last !== it.el) begin
                    bad++;
                    $display("FAIL t%0d.r%0d key_last got=%b want=%b", it.t, it.idx, key_last, it.el);
                end
                if (it.rec) obs_k[it.idx] = key_ina ^ key_inb;
                if (it.fin) begin
                    x = PT1[127:64];
                    y = PT1[63:0];
                    for (int i = 0; i < 68; i++) begin
                        tmp = x;
                        x   = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ obs_k[i];
                        y   = tmp;
                    end
                    total++;
                    if ({x, y} !== CT1) begin
                        bad++;
                        $display("FAIL t%0d ciphertext got=%h want=%h", it.t, {x, y}, CT1);
                    end
                end
            end
        end
        if (done_req && !done_ack) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL sb_drain got_left=%0d want_left=0", sb.size());
            end
            done_ack = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r1, r2, r3;
        rst_n = 1'b0; data_rdy = 2'd0; counter = 8'd0;
        key_bit_a = 1'b0; key_bit_b = 1'b0; mrnd = 0;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        expect_keys(8'd0, 8'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Load, full run with saturation, golden ciphertext from the recovered round keys.
        load_keys(r1, r1 ^ KEY1, KEY1);
        expect_model(8'd1, 1'b1, 1'b0);
        run(8'd2, 0, 140, 1'b1);

        // Reload clears key_last; holds mid-run; reload with a new key at round 20.
        load_keys(r2, r2 ^ KEY1, KEY1);
        expect_model(8'd4, 1'b0, 1'b0);
        run(8'd4, 0, 30, 1'b0);
        hold(8'd4, 2'd0, 10);
        hold(8'd4, 2'd2, 10);
        run(8'd4, 31, 40, 1'b0);
        load_keys(r3, r3 ^ KEY2, KEY2);
        expect_model(8'd5, 1'b0, 1'b0);
        run(8'd5, 0, 140, 1'b0);

        // Asynchronous reset between clock edges, then a fresh load and run.
        load_keys(r1, r1 ^ KEY1, KEY1);
        run(8'd6, 0, 5, 1'b0);
        data_rdy = 2'd0;
        tick();
        #2;
        rst_n = 1'b0;
        expect_keys(8'd6, 8'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        load_keys(r2, r2 ^ KEY1, KEY1);
        expect_model(8'd7, 1'b0, 1'b0);
        run(8'd7, 0, 3, 1'b0);

        done_req = 1'b1;
        for (int i = 0; i < 5 && !done_ack; i++) @(negedge clk);
        #1;
        if (!done_ack) $display("FAIL drain_ack got=0 want=1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
